dmem_responder: RTL and testbench

- Data-memory responder at the far end of the MEM-stage memory request interface.
- Consumes the registered load/store requests (ren/raddr, wen/waddr/wdata/wmask) presented by the EX/MEM pipeline register.
- Commits stores with a byte mask into an internal 64-bit word array. Services loads with a fixed, parameterised latency.
- Holds the pipeline (hold_o) while a load is outstanding and returns load data to the MEM/WB path.

---
 rtl/dmem_responder_pkg.sv | 24 ++
 rtl/dmem_ram.sv | 42 ++++
 rtl/dmem_responder.sv | 109 ++++++++++
 tb/tb_dmem_responder.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// dmem_responder shared types and helpers.
// FSM encoding, zero constant and byte-mask expansion.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [63:0] ZERO64 = 64'b0;

  function automatic logic [63:0] mask_to_bits(
    input logic [7:0] m
  );
    logic [63:0] b;
    b = '0;
    for (int i = 0; i < 8; i++) begin
      b[8*i +: 8] = {8{m[i]}};
    end
    return b;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Byte-masked 64-bit word array, one write port, one synchronous read port.
// A same-edge write to the read word is forwarded so the read sees new data.
module dmem_ram
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [63:0]       i_wdata,
  input  logic [7:0]        i_wmask,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [63:0]       o_rdata
);

  logic [63:0] r_mem [2**ADDR_W];
  logic [63:0] w_bits;

  assign w_bits = mask_to_bits(i_wmask);

  // byte-enabled write, contents never reset
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int i = 0; i < 8; i++) begin
        if (i_wmask[i]) begin
          r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
        end
      end
    end
  end

  // synchronous read, write-first on an address match
  always_ff @(posedge clk) begin
    if (i_we && (i_waddr == i_raddr)) begin
      o_rdata <= (r_mem[i_raddr] & ~w_bits) | (i_wdata & w_bits);
    end else begin
      o_rdata <= r_mem[i_raddr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data memory responder: masked stores, fixed-latency loads,
// pipeline hold while a load is outstanding, out-of-range error pulses.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ren_i,
  input  logic [63:0] raddr_i,
  input  logic        wen_i,
  input  logic [63:0] waddr_i,
  input  logic [63:0] wdata_i,
  input  logic [7:0]  wmask_i,
  output logic [63:0] rdata_o,
  output logic        rvalid_o,
  output logic        hold_o,
  output logic        err_o
);

  localparam logic [3:0] CNT_INIT = 4'(RD_LAT - 1);

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic [ADDR_W-1:0]   r_idx;
  logic                r_oor;

  logic [ADDR_W-1:0]   w_widx;
  logic [ADDR_W-1:0]   w_ridx;
  logic                w_woor;
  logic                w_roor;
  logic                w_idle;
  logic                w_we;
  logic [ADDR_W-1:0]   w_ram_raddr;
  logic [63:0]         w_ram_q;
  logic                w_unused;

  assign w_widx = waddr_i[ADDR_W+2:3];
  assign w_ridx = raddr_i[ADDR_W+2:3];
  assign w_woor = |waddr_i[63:ADDR_W+3];
  assign w_roor = |raddr_i[63:ADDR_W+3];
  assign w_unused = ^{waddr_i[2:0], raddr_i[2:0]};

  assign w_idle = (r_state == ST_IDLE);
  assign w_we = w_idle & wen_i & ~w_woor & ~rst;
  assign w_ram_raddr = w_idle ? w_ridx : r_idx;

  assign hold_o = (r_state == ST_BUSY) | (w_idle & ren_i);

  dmem_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_widx),
    .i_wdata (wdata_i),
    .i_wmask (wmask_i),
    .i_raddr (w_ram_raddr),
    .o_rdata (w_ram_q)
  );

  // request FSM, latency counter and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 4'd0;
      r_idx    <= '0;
      r_oor    <= 1'b0;
      rdata_o  <= ZERO64;
      rvalid_o <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      rvalid_o <= 1'b0;
      err_o    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (wen_i && w_woor) begin
            err_o <= 1'b1;
          end
          if (ren_i) begin
            r_idx   <= w_ridx;
            r_oor   <= w_roor;
            r_cnt   <= CNT_INIT;
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (r_cnt == 4'd0) begin
            rdata_o  <= r_oor ? ZERO64 : w_ram_q;
            rvalid_o <= 1'b1;
            err_o    <= r_oor;
            r_state  <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed cases plus random ops
// compared against a byte-level memory model.
module tb_dmem_responder;

  localparam int AW    = 10;
  localparam int LAT   = 2;
  localparam int WORDS = 1 << AW;

  logic        clk = 1'b0;
  logic        rst;
  logic        ren_i;
  logic [63:0] raddr_i;
  logic        wen_i;
  logic [63:0] waddr_i;
  logic [63:0] wdata_i;
  logic [7:0]  wmask_i;
  logic [63:0] rdata_o;
  logic        rvalid_o;
  logic        hold_o;
  logic        err_o;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [63:0] model [WORDS];
  logic [63:0] last_rd;

  dmem_responder #(
    .ADDR_W (AW),
    .RD_LAT (LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ren_i    (ren_i),
    .raddr_i  (raddr_i),
    .wen_i    (wen_i),
    .waddr_i  (waddr_i),
    .wdata_i  (wdata_i),
    .wmask_i  (wmask_i),
    .rdata_o  (rdata_o),
    .rvalid_o (rvalid_o),
    .hold_o   (hold_o),
    .err_o    (err_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic bit oor(input logic [63:0] a);
    return a >= 64'(WORDS * 8);
  endfunction

  function automatic int widx(input logic [63:0] a);
    return int'((a / 8) % WORDS);
  endfunction

  task automatic model_store(
    input logic [63:0] a,
    input logic [63:0] d,
    input logic [7:0]  m
  );
    if (!oor(a)) begin
      for (int b = 0; b < 8; b++) begin
        if (m[b]) model[widx(a)][8*b +: 8] = d[8*b +: 8];
      end
    end
  endtask

  // one request cycle (store, load or both) and its full response window
  task automatic op(
    input  bit          st,
    input  logic [63:0] sa,
    input  logic [63:0] sd,
    input  logic [7:0]  sm,
    input  bit          ld,
    input  logic [63:0] la,
    output int          rv_cyc
  );
    bit          soor;
    logic [63:0] exp;
    soor   = st && oor(sa);
    rv_cyc = -1;
    ren_i   = ld;
    raddr_i = la;
    wen_i   = st;
    waddr_i = sa;
    wdata_i = sd;
    wmask_i = sm;
    @(negedge clk);
    check("hold_c0", 64'(hold_o), 64'(ld));
    check("rvalid_c0", 64'(rvalid_o), 64'd0);
    check("err_c0", 64'(err_o), 64'd0);
    if (st) model_store(sa, sd, sm);
    @(posedge clk);
    #1;
    wen_i = 1'b0;
    if (ld) begin
      exp = oor(la) ? 64'd0 : model[widx(la)];
      for (int k = 1; k <= LAT; k++) begin
        @(negedge clk);
        check("hold_busy", 64'(hold_o), 64'd1);
        check("rvalid_busy", 64'(rvalid_o), 64'd0);
        check("rdata_held", rdata_o, last_rd);
        check("err_busy", 64'(err_o), 64'((k == 1) && soor));
        @(posedge clk);
        #1;
      end
      ren_i = 1'b0;
      @(negedge clk);
      check("rvalid_resp", 64'(rvalid_o), 64'd1);
      check("hold_resp", 64'(hold_o), 64'd0);
      check("rdata_resp", rdata_o, exp);
      check("err_resp", 64'(err_o), 64'(oor(la)));
      rv_cyc  = cyc;
      last_rd = exp;
      @(posedge clk);
      #1;
    end else begin
      ren_i = 1'b0;
      @(negedge clk);
      check("err_st", 64'(err_o), 64'(soor));
      check("hold_st", 64'(hold_o), 64'd0);
      check("rvalid_st", 64'(rvalid_o), 64'd0);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int          r1;
    int          r2;
    int          dmy;
    int          sel;
    logic [63:0] a;
    logic [63:0] b;
    rst     = 1'b1;
    ren_i   = 1'b0;
    raddr_i = '0;
    wen_i   = 1'b0;
    waddr_i = '0;
    wdata_i = '0;
    wmask_i = '0;
    last_rd = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rdata", rdata_o, 64'd0);
    check("rst_rvalid", 64'(rvalid_o), 64'd0);
    check("rst_err", 64'(err_o), 64'd0);
    check("rst_hold", 64'(hold_o), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < WORDS; i++) begin
      model[i] = '0;
      op(1'b1, 64'(i * 8), 64'd0, 8'hFF, 1'b0, 64'd0, dmy);
    end

    op(1'b1, 64'h40, 64'h1122334455667788, 8'hFF, 1'b0, 64'd0, dmy);
    op(1'b0, 64'd0, 64'd0, 8'h00, 1'b1, 64'h40, dmy);
    check("full_store", rdata_o, 64'h1122334455667788);

    op(1'b1, 64'h40, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 1'b0, 64'd0, dmy);
    op(1'b0, 64'd0, 64'd0, 8'h00, 1'b1, 64'h40, dmy);
    check("partial", rdata_o, 64'h11223344AAAAAAAA);

    op(1'b1, 64'h48, 64'h0F0E0D0C0B0A0908, 8'hFF, 1'b0, 64'd0, dmy);
    op(1'b0, 64'd0, 64'd0, 8'h00, 1'b1, 64'h40, r1);
    op(1'b0, 64'd0, 64'd0, 8'h00, 1'b1, 64'h48, r2);
    check("b2b_gap", 64'(r2 - r1), 64'(LAT + 2));
    check("b2b_second", rdata_o, 64'h0F0E0D0C0B0A0908);

    op(1'b1, 64'h50, 64'h0123456789ABCDEF, 8'hFF, 1'b0, 64'd0, dmy);
    op(1'b1, 64'h50, 64'hDEADBEEF00000000, 8'hF0, 1'b1, 64'h50, dmy);
    check("raw_same", rdata_o, 64'hDEADBEEF89ABCDEF);

    op(1'b1, 64'h2000, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 1'b0, 64'd0, dmy);
    op(1'b0, 64'd0, 64'd0, 8'h00, 1'b1, 64'h0, dmy);
    check("oor_st_word0", rdata_o, 64'd0);
    op(1'b0, 64'd0, 64'd0, 8'h00, 1'b1, 64'h2000, dmy);
    check("oor_ld_data", rdata_o, 64'd0);

    ren_i   = 1'b1;
    raddr_i = 64'h40;
    @(posedge clk);
    #1;
    ren_i = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_rdata", rdata_o, 64'd0);
    check("mid_rst_rvalid", 64'(rvalid_o), 64'd0);
    check("mid_rst_err", 64'(err_o), 64'd0);
    check("mid_rst_hold", 64'(hold_o), 64'd0);
    @(posedge clk);
    #1;
    rst     = 1'b0;
    last_rd = '0;
    for (int k = 0; k < LAT + 3; k++) begin
      @(negedge clk);
      check("no_rvalid_after_rst", 64'(rvalid_o), 64'd0);
      @(posedge clk);
      #1;
    end
    op(1'b0, 64'd0, 64'd0, 8'h00, 1'b1, 64'h40, dmy);

    for (int n = 0; n < 300; n++) begin
      sel = int'($urandom_range(0, 2));
      a = 64'($urandom_range(0, 15) * 8 + $urandom_range(0, 7));
      b = 64'($urandom_range(0, 15) * 8 + $urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) a = {$urandom, $urandom} | 64'h2000;
      if ($urandom_range(0, 9) == 0) b = 64'h2000 + 64'($urandom_range(0, 4095));
      op(sel != 1, a, {$urandom, $urandom}, 8'($urandom),
         sel != 0, b, dmy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
